// File: rtl/xif_bridge_pkg.sv
// Shared types for the tracked X-IF bridge:
// scoreboard entry states, result bundle and ID-space sizing.
package xif_bridge_pkg;

    localparam int XB_ID_WIDTH  = 4;
    localparam int XB_RFW_WIDTH = 32;
    localparam int NUM_IDS      = 2**XB_ID_WIDTH;

    typedef enum logic [1:0] {
        XE_FREE         = 2'd0,
        XE_ISSUED_WB    = 2'd1,
        XE_ISSUED_NOWB  = 2'd2,
        XE_COMMITTED_WB = 2'd3
    } xif_entry_e;

    typedef struct packed {
        logic [XB_ID_WIDTH-1:0]  id;
        logic [XB_RFW_WIDTH-1:0] data;
        logic [4:0]              rd;
        logic                    we;
    } xif_result_t;

    function automatic xif_entry_e issue_state(input logic wb);
        return wb ? XE_ISSUED_WB : XE_ISSUED_NOWB;
    endfunction

endpackage

// File: rtl/xif_result_fifo.sv
// Synchronous first-word fall-through FIFO with full/empty flags.
// Storage is registered, so a pushed word is visible the next cycle.
module xif_result_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    output logic full_o,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push    = push_i & ~full_o;
    assign pop     = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= nxt(wr_q);
            if (pop)  rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/xif_bridge_tracked.sv
// X-IF bridge with outstanding-ID scoreboard, credit gating on issue,
// and a buffered result path that drops results for uncommitted IDs.
module xif_bridge_tracked
    import xif_bridge_pkg::*;
#(
    parameter int X_ID_WIDTH        = 4,
    parameter int X_NUM_RS          = 2,
    parameter int X_RFR_WIDTH       = 32,
    parameter int X_RFW_WIDTH       = 32,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int RESULT_FIFO_DEPTH = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            core_issue_valid_i,
    output logic                            core_issue_ready_o,
    input  logic [31:0]                     core_issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]           core_issue_id_i,
    input  logic [2*X_RFR_WIDTH-1:0]        core_rs_i,
    input  logic [1:0]                      core_rs_valid_i,
    output logic                            core_issue_accept_o,
    output logic                            core_issue_writeback_o,
    input  logic                            core_commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]           core_commit_id_i,
    input  logic                            core_commit_kill_i,
    output logic                            core_result_valid_o,
    input  logic                            core_result_ready_i,
    output logic [X_ID_WIDTH-1:0]           core_result_id_o,
    output logic [X_RFW_WIDTH-1:0]          core_result_data_o,
    output logic [4:0]                      core_result_rd_o,
    output logic                            core_result_we_o,
    output logic                            x_issue_valid_o,
    input  logic                            x_issue_ready_i,
    output logic [31:0]                     x_issue_instr_o,
    output logic [X_ID_WIDTH-1:0]           x_issue_id_o,
    output logic [X_NUM_RS*X_RFR_WIDTH-1:0] x_issue_rs_o,
    output logic [X_NUM_RS-1:0]             x_issue_rs_valid_o,
    input  logic                            x_issue_accept_i,
    input  logic                            x_issue_writeback_i,
    output logic                            x_commit_valid_o,
    output logic [X_ID_WIDTH-1:0]           x_commit_id_o,
    output logic                            x_commit_kill_o,
    input  logic                            x_result_valid_i,
    output logic                            x_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]           x_result_id_i,
    input  logic [X_RFW_WIDTH-1:0]          x_result_data_i,
    input  logic [4:0]                      x_result_rd_i,
    input  logic                            x_result_we_i,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int NUM_ENT = 2**X_ID_WIDTH;
    localparam int CW      = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
    } res_t;

    xif_entry_e    ent_q [NUM_ENT];
    xif_entry_e    ent_d [NUM_ENT];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          blocked, issue_hs, push_hs, fifo_push;
    logic          fifo_full, fifo_empty, inc;
    logic [1:0]    dec;
    res_t          push_data, pop_data;

    assign blocked  = (cnt_q == CW'(MAX_OUTSTANDING))
                    | (ent_q[core_issue_id_i] != XE_FREE);
    assign x_issue_valid_o    = core_issue_valid_i & ~blocked;
    assign core_issue_ready_o = x_issue_ready_i & ~blocked;
    assign issue_hs           = x_issue_valid_o & x_issue_ready_i;

    assign x_issue_instr_o        = core_issue_instr_i;
    assign x_issue_id_o           = core_issue_id_i;
    assign core_issue_accept_o    = x_issue_accept_i;
    assign core_issue_writeback_o = x_issue_writeback_i;

    if (X_NUM_RS == 3) begin : g_rs3
        assign x_issue_rs_o       = {{X_RFR_WIDTH{1'b0}}, core_rs_i};
        assign x_issue_rs_valid_o = {1'b0, core_rs_valid_i};
    end else begin : g_rs2
        assign x_issue_rs_o       = core_rs_i;
        assign x_issue_rs_valid_o = core_rs_valid_i;
    end

    assign x_commit_valid_o = core_commit_valid_i;
    assign x_commit_id_o    = core_commit_id_i;
    assign x_commit_kill_o  = core_commit_kill_i;

    assign x_result_ready_o = ~fifo_full;
    assign push_hs          = x_result_valid_i & ~fifo_full;
    assign push_data        = '{id: x_result_id_i, data: x_result_data_i,
                                rd: x_result_rd_i, we: x_result_we_i};

    // Updates applied in order: issue, then commit, then result push.
    always_comb begin
        ent_d     = ent_q;
        inc       = 1'b0;
        dec       = 2'd0;
        err_d     = err_q;
        fifo_push = 1'b0;
        if (issue_hs && x_issue_accept_i) begin
            ent_d[core_issue_id_i] = issue_state(x_issue_writeback_i);
            inc = 1'b1;
        end
        if (core_commit_valid_i) begin
            case (ent_d[core_commit_id_i])
                XE_FREE: err_d = 1'b1;
                XE_ISSUED_NOWB: begin
                    ent_d[core_commit_id_i] = XE_FREE;
                    dec = dec + 2'd1;
                end
                XE_ISSUED_WB: begin
                    if (core_commit_kill_i) begin
                        ent_d[core_commit_id_i] = XE_FREE;
                        dec = dec + 2'd1;
                    end else begin
                        ent_d[core_commit_id_i] = XE_COMMITTED_WB;
                    end
                end
                default: ;
            endcase
        end
        if (push_hs) begin
            if (ent_d[x_result_id_i] == XE_COMMITTED_WB) begin
                ent_d[x_result_id_i] = XE_FREE;
                dec = dec + 2'd1;
                fifo_push = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        cnt_d = cnt_q + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ENT; i++) ent_q[i] <= XE_FREE;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    xif_result_fifo #(
        .DEPTH (RESULT_FIFO_DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (push_data),
        .full_o  (fifo_full),
        .pop_i   (core_result_ready_i),
        .data_o  (pop_data),
        .empty_o (fifo_empty)
    );

    assign core_result_valid_o = ~fifo_empty;
    assign core_result_id_o    = pop_data.id;
    assign core_result_data_o  = pop_data.data;
    assign core_result_rd_o    = pop_data.rd;
    assign core_result_we_o    = pop_data.we;

    assign busy_o = (cnt_q != '0) | ~fifo_empty;
    assign err_o  = err_q;

endmodule

// File: tb/tb_xif_bridge_tracked.sv
// Bench for xif_bridge_tracked: directed scenarios plus random traffic
// compared cycle by cycle with a per-ID bookkeeping model.
module tb_xif_bridge_tracked;

    localparam int IDW  = 4;
    localparam int RW   = 32;
    localparam int MAXO = 4;
    localparam int DEP  = 2;
    localparam int NID  = 2**IDW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            iss_valid, x_iss_rdy, acc, wb;
    logic [31:0]     instr;
    logic [IDW-1:0]  iss_id, cm_id, r_id;
    logic [2*RW-1:0] rs;
    logic [1:0]      rs_v;
    logic            cm_valid, cm_kill, r_valid, r_we, c_rdy;
    logic [RW-1:0]   r_data;
    logic [4:0]      r_rd;

    logic            core_issue_ready_o, core_issue_accept_o;
    logic            core_issue_writeback_o, core_result_valid_o;
    logic [IDW-1:0]  core_result_id_o, x_issue_id_o, x_commit_id_o;
    logic [RW-1:0]   core_result_data_o;
    logic [4:0]      core_result_rd_o;
    logic            core_result_we_o, x_issue_valid_o;
    logic [31:0]     x_issue_instr_o;
    logic [2*RW-1:0] x_issue_rs_o;
    logic [1:0]      x_issue_rs_valid_o;
    logic            x_commit_valid_o, x_commit_kill_o;
    logic            x_result_ready_o, busy_o, err_o;

    always #5 clk = ~clk;

    xif_bridge_tracked dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_issue_valid_i(iss_valid),
        .core_issue_ready_o(core_issue_ready_o),
        .core_issue_instr_i(instr), .core_issue_id_i(iss_id),
        .core_rs_i(rs), .core_rs_valid_i(rs_v),
        .core_issue_accept_o(core_issue_accept_o),
        .core_issue_writeback_o(core_issue_writeback_o),
        .core_commit_valid_i(cm_valid), .core_commit_id_i(cm_id),
        .core_commit_kill_i(cm_kill),
        .core_result_valid_o(core_result_valid_o),
        .core_result_ready_i(c_rdy),
        .core_result_id_o(core_result_id_o),
        .core_result_data_o(core_result_data_o),
        .core_result_rd_o(core_result_rd_o),
        .core_result_we_o(core_result_we_o),
        .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_iss_rdy),
        .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
        .x_issue_rs_o(x_issue_rs_o),
        .x_issue_rs_valid_o(x_issue_rs_valid_o),
        .x_issue_accept_i(acc), .x_issue_writeback_i(wb),
        .x_commit_valid_o(x_commit_valid_o),
        .x_commit_id_o(x_commit_id_o),
        .x_commit_kill_o(x_commit_kill_o),
        .x_result_valid_i(r_valid), .x_result_ready_o(x_result_ready_o),
        .x_result_id_i(r_id), .x_result_data_i(r_data),
        .x_result_rd_i(r_rd), .x_result_we_i(r_we),
        .busy_o(busy_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: per-ID "in flight", "will write back", "committed" flags
    // and an ordered list of delivered results.
    typedef struct {
        logic [IDW-1:0] id;
        logic [RW-1:0]  data;
        logic [4:0]     rd;
        logic           we;
    } res_t;

    bit   m_live [NID];
    bit   m_wb   [NID];
    bit   m_done [NID];
    bit   m_err;
    res_t m_q [$];

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NID; i++) n += int'(m_live[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NID; i++) begin
            m_live[i] = 0; m_wb[i] = 0; m_done[i] = 0;
        end
        m_err = 0;
        m_q.delete();
    endtask

    task automatic idle();
        iss_valid = 0; x_iss_rdy = 1; acc = 1; wb = 1;
        instr = 32'h0; iss_id = '0; rs = '0; rs_v = '0;
        cm_valid = 0; cm_id = '0; cm_kill = 0;
        r_valid = 0; r_id = '0; r_data = '0; r_rd = '0; r_we = 0;
        c_rdy = 1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rvalid"}, core_result_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_xrdy"}, x_result_ready_o, 1);
        chk({tag, "_ivalid"}, x_issue_valid_o, iss_valid);
        chk({tag, "_irdy"}, core_issue_ready_o, x_iss_rdy);
    endtask

    // One clock: check outputs mid-cycle, then advance the model.
    task automatic cyc();
        bit blk, rdy, hs;
        @(negedge clk);
        blk = (m_cnt() == MAXO) || m_live[iss_id];
        rdy = m_q.size() < DEP;
        chk("x_issue_valid", x_issue_valid_o, iss_valid && !blk);
        chk("issue_ready", core_issue_ready_o, x_iss_rdy && !blk);
        chk("x_result_ready", x_result_ready_o, rdy);
        chk("result_valid", core_result_valid_o, m_q.size() > 0);
        if (m_q.size() > 0)
            chk("result_bundle",
                {core_result_id_o, core_result_data_o,
                 core_result_rd_o, core_result_we_o},
                {m_q[0].id, m_q[0].data, m_q[0].rd, m_q[0].we});
        chk("busy", busy_o, (m_cnt() > 0) || (m_q.size() > 0));
        chk("err", err_o, m_err);
        chk("pass_issue",
            {x_issue_instr_o, x_issue_id_o, core_issue_accept_o,
             core_issue_writeback_o}, {instr, iss_id, acc, wb});
        chk("pass_rs", x_issue_rs_o, rs);
        chk("pass_rs_valid", x_issue_rs_valid_o, rs_v);
        chk("pass_commit",
            {x_commit_valid_o, x_commit_id_o, x_commit_kill_o},
            {cm_valid, cm_id, cm_kill});

        hs = iss_valid && x_iss_rdy && !blk;
        if (hs && acc) begin
            m_live[iss_id] = 1; m_wb[iss_id] = wb; m_done[iss_id] = 0;
        end
        if (cm_valid) begin
            if (!m_live[cm_id]) m_err = 1;
            else if (!m_done[cm_id]) begin
                if (cm_kill || !m_wb[cm_id]) m_live[cm_id] = 0;
                else m_done[cm_id] = 1;
            end
        end
        if (c_rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (r_valid && rdy) begin
            if (m_live[r_id] && m_done[r_id]) begin
                m_q.push_back('{id: r_id, data: r_data, rd: r_rd, we: r_we});
                m_live[r_id] = 0; m_done[r_id] = 0;
            end else begin
                m_err = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input bit a, input bit w);
        idle(); iss_valid = 1; iss_id = IDW'(id); acc = a; wb = w;
        instr = $urandom; cyc();
    endtask

    task automatic commit(input int id, input bit k);
        idle(); cm_valid = 1; cm_id = IDW'(id); cm_kill = k; cyc();
    endtask

    task automatic result(input int id, input logic [31:0] d, input bit cr);
        idle(); r_valid = 1; r_id = IDW'(id); r_data = d;
        r_rd = 5'(id + 1); r_we = 1; c_rdy = cr; cyc();
    endtask

    initial begin
        idle();
        m_clear();
        #1;
        chk_reset_outs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // Basic round trip with one cycle held back before pop.
        issue(3, 1, 1);
        commit(3, 0);
        result(3, 32'hDEADBEEF, 0);
        chk("rt_data", core_result_data_o, 32'hDEADBEEF);
        idle(); c_rdy = 1; cyc();
        idle(); cyc();
        chk("rt_busy_after_pop", busy_o, 0);

        // Credit exhaustion then release by kill.
        for (int i = 0; i < 4; i++) issue(i, 1, 1);
        for (int i = 0; i < 3; i++) issue(4, 1, 1);
        idle(); iss_valid = 1; iss_id = 4; cm_valid = 1; cm_id = 0;
        cm_kill = 1; cyc();
        chk("credit_still_blocked_id4", m_live[4], 0);
        issue(4, 1, 1);

        // Reissue of a live ID is blocked until it is killed.
        issue(2, 1, 1);
        commit(2, 1);
        issue(2, 1, 0);
        for (int i = 1; i <= 4; i++) commit(i, (i != 2));
        commit(2, 0);
        idle(); cyc();
        chk("drain_busy", busy_o, 0);

        // Result for a free ID is dropped.
        result(5, 32'h1234_5678, 1);
        idle(); cyc();
        chk("drop_err", err_o, 1);
        chk("drop_empty", core_result_valid_o, 0);

        // Fill the result buffer with core stalled.
        for (int i = 6; i <= 8; i++) issue(i, 1, 1);
        for (int i = 6; i <= 8; i++) commit(i, 0);
        result(6, 32'hA0, 0);
        result(7, 32'hA1, 0);
        chk("full_xrdy", x_result_ready_o, 0);
        for (int k = 0; k < 3; k++) result(8, 32'hA2, 0);
        for (int k = 0; k < 6; k++) result(8, 32'hA2, 1);
        idle(); repeat (3) cyc();

        // Same-cycle issue+commit then a mid-flight reset.
        idle(); iss_valid = 1; iss_id = 1; cm_valid = 1; cm_id = 1;
        cyc();
        chk("same_cycle_busy", busy_o, 1);
        issue(9, 1, 1);
        #2;
        rst_n = 0;
        #1;
        idle();
        m_clear();
        #1;
        chk_reset_outs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(); cyc();

        // Random traffic over a small ID window for frequent collisions.
        for (int n = 0; n < 1500; n++) begin
            idle();
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_id    = IDW'($urandom_range(0, 7));
            acc       = ($urandom_range(0, 4) != 0);
            wb        = ($urandom_range(0, 2) != 0);
            x_iss_rdy = ($urandom_range(0, 3) != 0);
            instr     = $urandom;
            rs        = {$urandom, $urandom};
            rs_v      = 2'($urandom_range(0, 3));
            cm_valid  = ($urandom_range(0, 2) == 0);
            cm_id     = IDW'($urandom_range(0, 7));
            cm_kill   = ($urandom_range(0, 3) == 0);
            r_valid   = ($urandom_range(0, 2) == 0);
            r_id      = IDW'($urandom_range(0, 7));
            for (int j = 0; j < 8; j++)
                if (m_done[j] && $urandom_range(0, 1) == 1)
                    r_id = IDW'(j);
            r_data    = $urandom;
            r_rd      = 5'($urandom_range(0, 31));
            r_we      = 1'($urandom_range(0, 1));
            c_rdy     = ($urandom_range(0, 2) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
